// File: rtl/sb_pkg.sv
// Shared types and width helpers for the store buffer with load forwarding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sb_pkg;

  // Drain FSM: IDLE presents the head entry, WAIT holds it until the write completes.
  typedef enum logic {
    SB_IDLE = 1'b0,
    SB_WAIT = 1'b1
  } sb_state_e;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Default geometry and the widths derived from it.
  localparam int SB_DEPTH  = 4;
  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;
  localparam int SB_BE_W   = SB_DATA_W / 8;
  localparam int SB_PTR_W  = clog2(SB_DEPTH);

endpackage

// File: rtl/sb_byte_merge.sv
// Per-byte priority merge of DEPTH age-ordered buffer entries over a fallback word.
// Latency: purely combinational.
// Backpressure: none.
// Ports: data/strb/match are indexed by age (0 = oldest, DEPTH-1 = youngest);
//        fallback supplies any byte no matching entry writes; merged/hit_mask are the result.
module sb_byte_merge
  import sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int DATA_W = SB_DATA_W,
  localparam int BE_W  = DATA_W / 8
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] data,
  input  logic [DEPTH-1:0][BE_W-1:0]   strb,
  input  logic [DEPTH-1:0]             match,
  input  logic [DATA_W-1:0]            fallback,
  output logic [DATA_W-1:0]            merged,
  output logic [BE_W-1:0]              hit_mask
);

  // Walk oldest to youngest so a younger writer of a byte overrides an older one.
  always_comb begin
    merged   = fallback;
    hit_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      for (int b = 0; b < BE_W; b++) begin
        if (match[k] && strb[k][b]) begin
          merged[b*8 +: 8] = data[k][b*8 +: 8];
          hit_mask[b]      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer_fwd.sv
// In-order store buffer draining to an SRAM-like write port, with per-byte load forwarding.
// Latency: a store into an empty, idle buffer raises wr_req the next cycle; forwarding is combinational.
// Backpressure: st_ready drops when all DEPTH entries are occupied; one write outstanding at a time.
// Ports: st_* enqueue side; ld_* forwarding lookup; wr_* write request (addr_ok accepts,
//        data_ok completes and pops); sb_empty/sb_count occupancy.
module store_buffer_fwd
  import sb_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  localparam int BE_W  = DATA_W / 8,
  localparam int PTR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [BE_W-1:0]   st_wstrb,
  input  logic [DATA_W-1:0] st_wdata,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data_in,
  output logic [DATA_W-1:0] ld_data_out,
  output logic [BE_W-1:0]   ld_hit_mask,
  output logic              ld_full_hit,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [BE_W-1:0]   wr_wstrb,
  output logic [DATA_W-1:0] wr_wdata,
  input  logic              wr_addr_ok,
  input  logic              wr_data_ok,
  output logic              sb_empty,
  output logic [PTR_W:0]    sb_count
);

  // Low address bits that select a byte within a word; ignored when matching.
  localparam int OFF_W = clog2(BE_W);

  logic [ADDR_W-1:0] e_addr [DEPTH];
  logic [BE_W-1:0]   e_strb [DEPTH];
  logic [DATA_W-1:0] e_data [DEPTH];
  logic [DEPTH-1:0]  e_vld;

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W:0]    count;
  sb_state_e         state;
  sb_state_e         state_nxt;
  logic              push;
  logic              pop;

  assign sb_empty = (count == '0);
  assign sb_count = count;
  assign st_ready = (count != (PTR_W+1)'(DEPTH));
  assign push     = st_valid && st_ready;
  // Only a completion while waiting retires the head; stray data_ok in IDLE is dropped.
  assign pop      = (state == SB_WAIT) && wr_data_ok;

  assign wr_addr  = e_addr[head];
  assign wr_wstrb = e_strb[head];
  assign wr_wdata = e_data[head];

  // Drain FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= SB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_req    = 1'b0;
    case (state)
      SB_IDLE: begin
        wr_req = !sb_empty;
        if (wr_req && wr_addr_ok) begin
          state_nxt = SB_WAIT;
        end
      end
      SB_WAIT: begin
        if (wr_data_ok) begin
          state_nxt = SB_IDLE;
        end
      end
      default: state_nxt = SB_IDLE;
    endcase
  end

  // Pointers, occupancy and valid bits. Push and pop never target the same slot:
  // head == tail with entries present means full, and a full buffer refuses pushes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      e_vld <= '0;
    end else begin
      if (push) begin
        tail        <= tail + PTR_W'(1);
        e_vld[tail] <= 1'b1;
      end
      if (pop) begin
        head        <= head + PTR_W'(1);
        e_vld[head] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; it is only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (push) begin
      e_addr[tail] <= st_addr;
      e_strb[tail] <= st_wstrb;
      e_data[tail] <= st_wdata;
    end
  end

  // Re-index the ring by age so the merge sees oldest at 0 and youngest at DEPTH-1,
  // which keeps priority correct regardless of where the pointers have wrapped.
  logic [DEPTH-1:0][DATA_W-1:0] age_data;
  logic [DEPTH-1:0][BE_W-1:0]   age_strb;
  logic [DEPTH-1:0]             age_match;

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    logic [PTR_W-1:0] slot;
    assign slot         = head + PTR_W'(k);
    assign age_data[k]  = e_data[slot];
    assign age_strb[k]  = e_strb[slot];
    assign age_match[k] = e_vld[slot] &&
                          (e_addr[slot][ADDR_W-1:OFF_W] == ld_addr[ADDR_W-1:OFF_W]);
  end

  if (OFF_W > 0) begin : g_off
    logic unused_ld_off;
    assign unused_ld_off = ^ld_addr[OFF_W-1:0];
  end

  sb_byte_merge #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_merge (
    .data     (age_data),
    .strb     (age_strb),
    .match    (age_match),
    .fallback (ld_data_in),
    .merged   (ld_data_out),
    .hit_mask (ld_hit_mask)
  );

  assign ld_full_hit = &ld_hit_mask;

endmodule

// File: tb/tb_store_buffer_fwd.sv
// Directed bench for store_buffer_fwd with a write-port scoreboard and a forwarding model.
// Latency: n/a.
// Backpressure: the bench plays the write slave with directed and randomised handshake delays.
module tb_store_buffer_fwd;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [3:0]  st_wstrb = '0;
  logic [31:0] st_wdata = '0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data_in = '0;
  logic [31:0] ld_data_out;
  logic [3:0]  ld_hit_mask;
  logic        ld_full_hit;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [3:0]  wr_wstrb;
  logic [31:0] wr_wdata;
  logic        wr_addr_ok = 1'b0;
  logic        wr_data_ok = 1'b0;
  logic        sb_empty;
  logic [2:0]  sb_count;

  always #5 clk = ~clk;

  store_buffer_fwd #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_addr     (st_addr),
    .st_wstrb    (st_wstrb),
    .st_wdata    (st_wdata),
    .ld_addr     (ld_addr),
    .ld_data_in  (ld_data_in),
    .ld_data_out (ld_data_out),
    .ld_hit_mask (ld_hit_mask),
    .ld_full_hit (ld_full_hit),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_wstrb    (wr_wstrb),
    .wr_wdata    (wr_wdata),
    .wr_addr_ok  (wr_addr_ok),
    .wr_data_ok  (wr_data_ok),
    .sb_empty    (sb_empty),
    .sb_count    (sb_count)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } ent_t;

  ent_t m_ent[$];   // model buffer contents, oldest first
  ent_t exp_q[$];   // expected write-port transactions, in enqueue order
  logic m_wait = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference behaviour of occupancy and the drain handshake, updated on each edge.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_ent.delete();
      exp_q.delete();
      m_wait = 1'b0;
    end else begin
      bit acc, pp, go;
      acc = st_valid && (m_ent.size() < DEPTH);
      pp  = m_wait && wr_data_ok;
      go  = !m_wait && (m_ent.size() != 0) && wr_addr_ok;
      if (pp) void'(m_ent.pop_front());
      if (acc) m_ent.push_back('{st_addr, st_wstrb, st_wdata});
      if (go) m_wait = 1'b1;
      else if (pp) m_wait = 1'b0;
    end
  end

  // Write-port monitor: request level against the model, fields against the scoreboard head.
  always @(negedge clk) begin
    if (resetn) begin
      logic exp_req;
      exp_req = !m_wait && (m_ent.size() != 0);
      chk("wr_req", 32'(wr_req), 32'(exp_req));
      if (wr_req) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_port: request for addr %h but none expected", wr_addr);
        end else begin
          chk("wr_addr", wr_addr, exp_q[0].addr);
          chk("wr_wstrb", 32'(wr_wstrb), 32'(exp_q[0].strb));
          chk("wr_wdata", wr_wdata, exp_q[0].data);
          if (wr_addr_ok) void'(exp_q.pop_front());
        end
      end
    end
  end

  function automatic void fwd_model(input logic [31:0] a, input logic [31:0] din,
                                    output logic [31:0] d, output logic [3:0] m);
    d = din;
    m = '0;
    foreach (m_ent[i]) begin
      if (m_ent[i].addr[31:2] == a[31:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (m_ent[i].strb[b]) begin
            d[b*8 +: 8] = m_ent[i].data[b*8 +: 8];
            m[b] = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic do_store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_wstrb = s;
    st_wdata = d;
    #1;
    chk("st_ready", 32'(st_ready), 32'(m_ent.size() < DEPTH));
    if (m_ent.size() < DEPTH) exp_q.push_back('{a, s, d});
    @(posedge clk);
    #1;
    st_valid = 1'b0;
  endtask

  task automatic drain_one(input int d1, input int d2);
    int t;
    t = 0;
    while (!wr_req && t < 200) begin
      cyc();
      t++;
    end
    if (!wr_req) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: wr_req got 0 required 1");
      return;
    end
    cyc(d1);
    wr_addr_ok = 1'b1;
    cyc();
    wr_addr_ok = 1'b0;
    cyc(d2);
    wr_data_ok = 1'b1;
    cyc();
    wr_data_ok = 1'b0;
  endtask

  task automatic chk_fwd(input string name, input logic [31:0] d, input logic [3:0] m);
    chk({name, "_data"}, ld_data_out, d);
    chk({name, "_mask"}, 32'(ld_hit_mask), 32'(m));
    chk({name, "_full"}, 32'(ld_full_hit), 32'(m == 4'hF));
  endtask

  task automatic chk_reset_outputs();
    ld_addr    = 32'h1000;
    ld_data_in = 32'h12345678;
    #1;
    chk("rst_st_ready", 32'(st_ready), 32'd1);
    chk("rst_wr_req", 32'(wr_req), 32'd0);
    chk("rst_sb_count", 32'(sb_count), 32'd0);
    chk("rst_sb_empty", 32'(sb_empty), 32'd1);
    chk_fwd("rst_fwd", 32'h12345678, 4'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ed;
    logic [3:0]  em;

    // Power-on reset
    #2 resetn = 1'b0;
    chk_reset_outputs();
    #19 resetn = 1'b1;
    cyc();

    // Single store, request held while the slave stalls address acceptance
    do_store(32'h1000, 4'hF, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      chk("hold_wr_req", 32'(wr_req), 32'd1);
      chk("hold_wr_addr", wr_addr, 32'h1000);
      cyc();
    end
    ld_addr    = 32'h1002;
    ld_data_in = 32'h0;
    #1;
    chk_fwd("single", 32'hDEADBEEF, 4'hF);
    drain_one(0, 1);

    // Younger store wins on overlapping bytes
    do_store(32'h2000, 4'b0011, 32'h0000AAAA);
    do_store(32'h2000, 4'b0110, 32'h00BBBB00);
    ld_addr    = 32'h2000;
    ld_data_in = 32'h11223344;
    #1;
    chk_fwd("youngest", 32'h11BBBBAA, 4'b0111);
    drain_one(0, 0);
    drain_one(1, 0);

    // Fill to capacity; the fifth store is dropped
    for (int i = 0; i < 4; i++) do_store(32'h100 + 32'(i * 4), 4'hF, 32'hA0 + 32'(i));
    chk("full_count", 32'(sb_count), 32'd4);
    chk("full_st_ready", 32'(st_ready), 32'd0);
    do_store(32'h110, 4'hF, 32'hBAD0BAD0);
    chk("full_drop_count", 32'(sb_count), 32'd4);
    drain_one(1, 2);
    chk("after_pop_count", 32'(sb_count), 32'd3);
    chk("after_pop_ready", 32'(st_ready), 32'd1);
    chk("after_pop_addr", wr_addr, 32'h104);

    // Reset with a write outstanding
    wr_addr_ok = 1'b1;
    cyc();
    wr_addr_ok = 1'b0;
    resetn = 1'b0;
    chk_reset_outputs();
    cyc(2);
    resetn = 1'b1;
    cyc();

    // Ten stores with random slave delays; pointers wrap twice
    ld_data_in = 32'hA5A5A5A5;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int t;
          t = 0;
          while (m_ent.size() == DEPTH && t < 200) begin
            cyc();
            t++;
          end
          do_store(32'h3000 + 32'(i * 4), 4'(i % 15 + 1), $urandom);
          ld_addr = 32'h3000 + 32'(i * 4);
          #1;
          fwd_model(ld_addr, ld_data_in, ed, em);
          chk_fwd("wrap_fwd", ed, em);
        end
      end
      begin
        for (int i = 0; i < 10; i++) drain_one($urandom_range(0, 3), $urandom_range(0, 3));
      end
    join
    cyc(2);
    chk("wrap_empty", 32'(sb_empty), 32'd1);

    // Same word written by entries at slots 2, 3, 0: age order across the wrap
    ld_data_in = 32'h0;
    do_store(32'h4000, 4'hF, 32'h11111111);
    do_store(32'h4000, 4'b0011, 32'h00002222);
    do_store(32'h4000, 4'b0001, 32'h00000033);
    ld_addr = 32'h4003;
    #1;
    chk_fwd("wrap_age", 32'h11112233, 4'hF);
    chk("wrap_age_count", 32'(sb_count), 32'd3);
    cyc();
    wr_addr_ok = 1'b1;
    cyc();
    wr_addr_ok = 1'b0;

    // Pop cycle: head still visible, a same-cycle store not yet visible, count unchanged
    wr_data_ok = 1'b1;
    st_valid   = 1'b1;
    st_addr    = 32'h5000;
    st_wstrb   = 4'hF;
    st_wdata   = 32'h55555555;
    exp_q.push_back('{32'h5000, 4'hF, 32'h55555555});
    ld_addr = 32'h4000;
    #1;
    chk_fwd("pop_cycle_head", 32'h11112233, 4'hF);
    ld_addr = 32'h5000;
    #1;
    chk_fwd("new_store_hidden", 32'h0, 4'h0);
    chk("pop_cycle_count", 32'(sb_count), 32'd3);
    @(posedge clk);
    #1;
    wr_data_ok = 1'b0;
    st_valid   = 1'b0;
    chk("push_pop_count", 32'(sb_count), 32'd3);
    ld_addr = 32'h4000;
    #1;
    chk_fwd("after_pop", 32'h00002233, 4'b0011);
    ld_addr = 32'h5000;
    #1;
    chk_fwd("new_store_visible", 32'h55555555, 4'hF);

    drain_one(0, 0);
    drain_one(2, 1);
    drain_one(0, 3);
    cyc(2);
    chk("final_empty", 32'(sb_empty), 32'd1);
    chk("final_count", 32'(sb_count), 32'd0);
    chk("final_scoreboard", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
